snake_body_scanner: RTL and testbench

- Consumer of the packed snake position vector produced by the snake movement logic; it reads that vector instead of writing it.
- On each start it snapshots the vector and walks the entries serially, one per clock, building a width*height occupancy bitmap.
- It flags head-to-body self collision and head-on-food. The renderer reads the bitmap cell by cell through a registered query port.

---
 rtl/snake_pkg.sv | 24 ++
 rtl/snake_bitmap.sv | 51 +++++
 rtl/snake_body_scanner.sv | 153 +++++++++++++++
 tb/tb_snake_body_scanner.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared board constants, direction codes and scanner state type for the snake game.
package snake_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned HEIGHT  = 24;
    localparam int unsigned CELLS   = WIDTH * HEIGHT;
    localparam int unsigned NUM_LEN = 10;
    localparam int unsigned MAX_LEN = 31;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/snake_bitmap.sv
// Occupancy bitmap: synchronous clear-all, one set port, one registered read port.
module snake_bitmap #(
    parameter int unsigned cells = 768,
    parameter int unsigned idx_w = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             set_en,
    input  logic [idx_w-1:0] set_idx,
    input  logic [idx_w-1:0] rd_idx,
    output logic             rd_data
);

    logic [cells-1:0] bits_q, bits_d;
    logic             rd_data_q, rd_data_d;
    logic             set_in_range, rd_in_range;

    assign set_in_range = 32'(set_idx) < cells;
    assign rd_in_range  = 32'(rd_idx) < cells;

    always_comb begin
        bits_d = bits_q;
        if (clear) begin
            bits_d = '0;
        end else if (set_en && set_in_range) begin
            bits_d[set_idx] = 1'b1;
        end
    end

    // Reads see the bitmap as it stood before this edge's update.
    always_comb begin
        rd_data_d = 1'b0;
        if (rd_in_range) begin
            rd_data_d = bits_q[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q    <= '0;
            rd_data_q <= 1'b0;
        end else begin
            bits_q    <= bits_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/snake_body_scanner.sv
// Snapshots the packed snake position vector and walks it serially into an occupancy
// bitmap, flagging head-to-body and head-on-food collisions.
module snake_body_scanner
    import snake_pkg::*;
#(
    parameter int unsigned max_len         = MAX_LEN,
    parameter int unsigned num_len         = NUM_LEN,
    parameter int unsigned width           = WIDTH,
    parameter int unsigned height          = HEIGHT,
    parameter int unsigned max_len_bit_len = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [max_len_bit_len-1:0]   len,
    input  logic [max_len*num_len-1:0]   pos_num,
    input  logic [num_len-1:0]           food_pos,
    input  logic [num_len-1:0]           query_pos,
    output logic                         query_hit,
    output logic                         busy,
    output logic                         done,
    output logic                         map_valid,
    output logic                         self_hit,
    output logic                         food_hit
);

    localparam int unsigned CELLS_P = width * height;
    localparam int unsigned LW      = max_len_bit_len;
    localparam int unsigned PW      = max_len * num_len;

    scan_state_t          state_q, state_d;
    logic [LW-1:0]        idx_q, idx_d;
    logic [LW-1:0]        len_snap_q, len_snap_d;
    logic [PW-1:0]        pos_snap_q, pos_snap_d;
    logic [num_len-1:0]   food_snap_q, food_snap_d;
    logic                 self_hit_q, self_hit_d;
    logic                 food_hit_q, food_hit_d;
    logic                 map_valid_q, map_valid_d;

    logic [LW-1:0]        len_clamped;
    logic [num_len-1:0]   head_cell;
    logic [num_len-1:0]   cur_cell;
    logic                 cur_in_board;
    logic                 bm_clear;
    logic                 bm_set;

    always_comb begin
        len_clamped = len;
        if (32'(len) > max_len) begin
            len_clamped = LW'(max_len);
        end
    end

    assign head_cell    = pos_snap_q[num_len-1:0];
    assign cur_cell     = pos_snap_q[idx_q*num_len +: num_len];
    assign cur_in_board = 32'(cur_cell) < CELLS_P;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_snap_d  = len_snap_q;
        pos_snap_d  = pos_snap_q;
        food_snap_d = food_snap_q;
        self_hit_d  = self_hit_q;
        food_hit_d  = food_hit_q;
        map_valid_d = map_valid_q;
        bm_clear    = 1'b0;
        bm_set      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pos_snap_d  = pos_num;
                    food_snap_d = food_pos;
                    len_snap_d  = len_clamped;
                    self_hit_d  = 1'b0;
                    food_hit_d  = 1'b0;
                    map_valid_d = 1'b0;
                    state_d     = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                bm_clear = 1'b1;
                idx_d    = '0;
                state_d  = ST_SCAN;
            end
            ST_SCAN: begin
                if (idx_q < len_snap_q) begin
                    // Off-board cells still use their cycle; the bitmap drops the write.
                    bm_set = 1'b1;
                    if ((idx_q != '0) && cur_in_board && (cur_cell == head_cell)) begin
                        self_hit_d = 1'b1;
                    end
                    if ((idx_q == '0) && (cur_cell == food_snap_q)) begin
                        food_hit_d = 1'b1;
                    end
                    idx_d = idx_q + LW'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                map_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            len_snap_q  <= '0;
            pos_snap_q  <= '0;
            food_snap_q <= '0;
            self_hit_q  <= 1'b0;
            food_hit_q  <= 1'b0;
            map_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_snap_q  <= len_snap_d;
            pos_snap_q  <= pos_snap_d;
            food_snap_q <= food_snap_d;
            self_hit_q  <= self_hit_d;
            food_hit_q  <= food_hit_d;
            map_valid_q <= map_valid_d;
        end
    end

    snake_bitmap #(
        .cells (CELLS_P),
        .idx_w (num_len)
    ) u_bitmap (
        .clk     (clk),
        .rst_n   (rst),
        .clear   (bm_clear),
        .set_en  (bm_set),
        .set_idx (cur_cell),
        .rd_idx  (query_pos),
        .rd_data (query_hit)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign map_valid = map_valid_q;
    assign self_hit  = self_hit_q;
    assign food_hit  = food_hit_q;

endmodule

// File: tb/tb_snake_body_scanner.sv
// Self-checking bench for snake_body_scanner: directed table, corner sequences, random scans.
module tb_snake_body_scanner;

    localparam int NCELL = 768;

    logic         clk;
    logic         rst;
    logic         start;
    logic [4:0]   len;
    logic [309:0] pos_num;
    logic [9:0]   food_pos;
    logic [9:0]   query_pos;
    logic         query_hit;
    logic         busy;
    logic         done;
    logic         map_valid;
    logic         self_hit;
    logic         food_hit;

    int n_cmp;
    int n_bad;

    bit ref_map [NCELL];
    bit ref_self;
    bit ref_food;

    typedef struct packed {
        logic [4:0]       len;
        logic [7:0][9:0]  ent;
        logic [9:0]       food;
        logic             exp_self;
        logic             exp_food;
    } vec_t;

    vec_t tbl [6];

    snake_body_scanner #(
        .max_len         (31),
        .num_len         (10),
        .width           (32),
        .height          (24),
        .max_len_bit_len (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .pos_num   (pos_num),
        .food_pos  (food_pos),
        .query_pos (query_pos),
        .query_hit (query_hit),
        .busy      (busy),
        .done      (done),
        .map_valid (map_valid),
        .self_hit  (self_hit),
        .food_hit  (food_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [309:0] rand_pos();
        logic [319:0] t;
        for (int w = 0; w < 10; w++) t[w*32 +: 32] = $urandom;
        return t[309:0];
    endfunction

    // Reference: occupancy set from on-board entries, head compared with body and food.
    task automatic model(input logic [4:0] l, input logic [309:0] pv, input logic [9:0] f);
        int head;
        head = int'(pv[9:0]);
        foreach (ref_map[i]) ref_map[i] = 1'b0;
        ref_self = 1'b0;
        ref_food = 1'b0;
        for (int k = 0; k < int'(l); k++) begin
            int c;
            c = int'(pv[k*10 +: 10]);
            if (c < NCELL) ref_map[c] = 1'b1;
            if (k == 0 && c == int'(f)) ref_food = 1'b1;
            if (k > 0 && c < NCELL && c == head) ref_self = 1'b1;
        end
    endtask

    task automatic run_scan(input logic [4:0] l, input logic [309:0] pv, input logic [9:0] f,
                            input int pulse_at, output int done_c, output int fall_c,
                            output int done_n);
        @(negedge clk);
        len = l; pos_num = pv; food_pos = f; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_c = -1; fall_c = -1; done_n = 0;
        for (int c = 1; c <= 80 && fall_c < 0; c++) begin
            pos_num  = rand_pos();
            len      = 5'($urandom);
            food_pos = 10'($urandom);
            start    = (c == pulse_at);
            @(posedge clk);
            #1;
            if (done) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
            if (!busy) fall_c = c;
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [4:0] l, input int done_c,
                                input int fall_c, input int done_n,
                                input bit exp_self, input bit exp_food);
        int bad_cells;
        int first_bad;
        chk({tag, " done_cycle"}, done_c, int'(l) + 2);
        chk({tag, " busy_fall"}, fall_c, int'(l) + 3);
        chk({tag, " done_width"}, done_n, 1);
        chk({tag, " map_valid"}, int'(map_valid), 1);
        chk({tag, " self_hit"}, int'(self_hit), int'(exp_self));
        chk({tag, " food_hit"}, int'(food_hit), int'(exp_food));
        bad_cells = 0;
        first_bad = -1;
        for (int i = 0; i < NCELL; i++) begin
            query_pos = 10'(i);
            @(posedge clk);
            #1;
            if (query_hit != ref_map[i]) begin
                bad_cells++;
                if (first_bad < 0) first_bad = i;
            end
        end
        chk({tag, " bitmap_bad_cells"}, bad_cells, 0);
        if (first_bad >= 0) $display("  first differing cell %0d", first_bad);
        query_pos = 10'd800;
        @(posedge clk);
        #1;
        chk({tag, " query_oob"}, int'(query_hit), 0);
    endtask

    initial begin
        int dc, fc, dn;
        logic [309:0] pv;
        logic [4:0]   l;
        logic [9:0]   f;
        int pulse;

        n_cmp = 0; n_bad = 0;
        rst = 1'b0; start = 1'b0; len = '0; pos_num = '0; food_pos = '0; query_pos = '0;

        tbl[0] = '{len: 5'd3, ent: {10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd98, 10'd99, 10'd100},
                   food: 10'd500, exp_self: 1'b0, exp_food: 1'b0};
        tbl[1] = '{len: 5'd5, ent: {10'd0, 10'd0, 10'd0, 10'd40, 10'd72, 10'd73, 10'd41, 10'd40},
                   food: 10'd0, exp_self: 1'b1, exp_food: 1'b0};
        tbl[2] = '{len: 5'd2, ent: {10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd201, 10'd200},
                   food: 10'd200, exp_self: 1'b0, exp_food: 1'b1};
        tbl[3] = '{len: 5'd2, ent: {10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd200, 10'd199},
                   food: 10'd200, exp_self: 1'b0, exp_food: 1'b0};
        tbl[4] = '{len: 5'd0, ent: {10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0},
                   food: 10'd0, exp_self: 1'b0, exp_food: 1'b0};
        tbl[5] = '{len: 5'd4, ent: {10'd0, 10'd0, 10'd0, 10'd0, 10'd31, 10'd0, 10'd800, 10'd767},
                   food: 10'd5, exp_self: 1'b0, exp_food: 1'b0};

        #23;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset map_valid", int'(map_valid), 0);
        chk("reset self_hit", int'(self_hit), 0);
        chk("reset food_hit", int'(food_hit), 0);
        chk("reset query_hit", int'(query_hit), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int t = 0; t < 6; t++) begin
            pv = rand_pos();
            for (int k = 0; k < 8; k++) pv[k*10 +: 10] = tbl[t].ent[k];
            model(tbl[t].len, pv, tbl[t].food);
            run_scan(tbl[t].len, pv, tbl[t].food, -1, dc, fc, dn);
            check_result($sformatf("tbl%0d", t), tbl[t].len, dc, fc, dn,
                         tbl[t].exp_self, tbl[t].exp_food);
        end

        // Second start while busy must not disturb a full-length scan.
        pv = rand_pos();
        for (int k = 0; k < 31; k++) pv[k*10 +: 10] = 10'(k * 7);
        model(5'd31, pv, 10'd0);
        run_scan(5'd31, pv, 10'd0, 3, dc, fc, dn);
        check_result("busy_start", 5'd31, dc, fc, dn, 1'b0, 1'b1);

        // Reset in the middle of a scan.
        pv = rand_pos();
        pv[9:0] = 10'd123;
        pv[19:10] = 10'd123;
        @(negedge clk);
        len = 5'd31; pos_num = pv; food_pos = 10'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("midscan busy_before", int'(busy), 1);
        chk("midscan self_before", int'(self_hit), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst map_valid", int'(map_valid), 0);
        chk("rst self_hit", int'(self_hit), 0);
        chk("rst food_hit", int'(food_hit), 0);
        @(negedge clk);
        rst = 1'b1;
        query_pos = 10'd123;
        @(posedge clk);
        #1;
        chk("rst query_cleared", int'(query_hit), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst stays_idle", int'(busy), 0);

        for (int r = 0; r < 20; r++) begin
            l = 5'($urandom_range(0, 31));
            pv = rand_pos();
            for (int k = 0; k < 31; k++) begin
                if ($urandom_range(0, 7) == 0) pv[k*10 +: 10] = 10'($urandom_range(768, 1023));
                else pv[k*10 +: 10] = 10'($urandom_range(0, 767));
            end
            if (l > 1 && $urandom_range(0, 2) == 0)
                pv[$urandom_range(1, int'(l) - 1)*10 +: 10] = pv[9:0];
            f = ($urandom_range(0, 1) == 0) ? pv[9:0] : 10'($urandom);
            case ($urandom_range(0, 2))
                0: pulse = -1;
                1: pulse = $urandom_range(1, int'(l) + 2);
                default: pulse = int'(l) + 3;
            endcase
            model(l, pv, f);
            run_scan(l, pv, f, pulse, dc, fc, dn);
            check_result($sformatf("rnd%0d", r), l, dc, fc, dn, ref_self, ref_food);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
